// File: rtl/rwc_puf_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rwc_puf_engine
// Description : Read-write collision PUF engine. For each challenge it runs
//               N_EVAL collision/clean evaluations on an external single-port
//               BRAM and produces a majority-voted response, a per-bit
//               instability mask and a sticky clean-check flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rwc_puf_engine #(
  parameter int            DW            = 32,
  parameter int            AW            = 10,
  parameter int            N_EVAL        = 5,
  parameter int            RD_LAT        = 1,
  parameter logic [DW-1:0] CLEAR_PATTERN = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          w_resetn,
  // challenge side
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] cha_data,
  input  logic [AW-1:0] cha_addr,
  input  logic          abort,
  // BRAM port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  // response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_write,
  output logic [DW-1:0] rsp_unstable,
  output logic [DW-1:0] rsp_clean,
  output logic          clean_err
);

  // Vote counter width: holds 0..N_EVAL without overflow.
  localparam int              CW          = $clog2(N_EVAL + 1);
  localparam logic [1:0]      c_LAT_LAST  = 2'(RD_LAT - 1);
  localparam logic [3:0]      c_EVAL_LAST = 4'(N_EVAL - 1);
  localparam logic [CW-1:0]   c_N_CNT     = CW'(N_EVAL);
  localparam logic [CW:0]     c_N_CMP     = (CW + 1)'(N_EVAL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_WAIT_W = 3'd2,
    S_CLEAR  = 3'd3,
    S_WAIT_C = 3'd4,
    S_FINAL  = 3'd5,
    S_HOLD   = 3'd6
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_cha;
  logic [1:0]    r_lat;
  logic [3:0]    r_eval;
  logic [CW-1:0] r_cnt [DW];

  logic [DW-1:0] w_vote;
  logic [DW-1:0] w_unst;
  logic          w_busy;

  // Abort is honoured only while an evaluation sequence is in flight.
  assign w_busy = (r_state != S_IDLE) && (r_state != S_HOLD);

  // Majority vote (strictly more than half, so an even tie gives 0) and
  // disagreement mask derived from the per-bit counters.
  always_comb begin
    w_vote = '0;
    w_unst = '0;
    for (int i = 0; i < DW; i++) begin
      w_vote[i] = ({r_cnt[i], 1'b0} > c_N_CMP);
      w_unst[i] = (r_cnt[i] != '0) && (r_cnt[i] != c_N_CNT);
    end
  end

  // Sequencer: all BRAM and response outputs are registered here and set on
  // entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      r_state      <= S_IDLE;
      r_cha        <= '0;
      r_lat        <= '0;
      r_eval       <= '0;
      for (int i = 0; i < DW; i++) r_cnt[i] <= '0;
      req_ready    <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      rsp_valid    <= 1'b0;
      rsp_write    <= '0;
      rsp_unstable <= '0;
      rsp_clean    <= '0;
      clean_err    <= 1'b0;
    end else if (abort && w_busy) begin
      // Drop the request; a write already on the port this cycle still lands.
      r_state   <= S_IDLE;
      r_lat     <= '0;
      r_eval    <= '0;
      for (int i = 0; i < DW; i++) r_cnt[i] <= '0;
      req_ready <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cha     <= cha_data;
            r_lat     <= '0;
            r_eval    <= '0;
            for (int i = 0; i < DW; i++) r_cnt[i] <= '0;
            clean_err <= 1'b0;
            req_ready <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cha_addr;
            mem_din   <= cha_data;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_lat   <= '0;
          r_state <= S_WAIT_W;
        end
        S_WAIT_W: begin
          if (r_lat == c_LAT_LAST) begin
            // Collision read-back is on the bus now: tally each bit.
            for (int i = 0; i < DW; i++) r_cnt[i] <= r_cnt[i] + CW'(mem_dout[i]);
            mem_en  <= 1'b1;
            mem_we  <= 1'b1;
            mem_din <= CLEAR_PATTERN;
            r_state <= S_CLEAR;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_CLEAR: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_lat   <= '0;
          r_state <= S_WAIT_C;
        end
        S_WAIT_C: begin
          if (r_lat == c_LAT_LAST) begin
            rsp_clean <= mem_dout;
            if (mem_dout != CLEAR_PATTERN) clean_err <= 1'b1;
            if (r_eval == c_EVAL_LAST) begin
              r_state <= S_FINAL;
            end else begin
              r_eval  <= r_eval + 4'd1;
              mem_en  <= 1'b1;
              mem_we  <= 1'b1;
              mem_din <= r_cha;
              r_state <= S_WRITE;
            end
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_FINAL: begin
          rsp_write    <= w_vote;
          rsp_unstable <= w_unst;
          rsp_valid    <= 1'b1;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rwc_puf_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rwc_puf_engine
// Description : Directed self-checking bench for rwc_puf_engine with a
//               behavioural collision BRAM model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rwc_puf_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic w_resetn;

  // default-parameter instance
  logic        req_valid, req_ready, abort, mem_en, mem_we;
  logic        rsp_valid, rsp_ready, clean_err;
  logic [31:0] cha_data, mem_din, mem_dout, rsp_write, rsp_unstable, rsp_clean;
  logic [9:0]  cha_addr, mem_addr;

  // DW=8, N_EVAL=4, RD_LAT=3 instance
  logic        req_valid_b, req_ready_b, abort_b, mem_en_b, mem_we_b;
  logic        rsp_valid_b, rsp_ready_b, clean_err_b;
  logic [7:0]  cha_data_b, mem_din_b, mem_dout_b, rsp_write_b, rsp_unstable_b, rsp_clean_b;
  logic [9:0]  cha_addr_b, mem_addr_b;

  rwc_puf_engine u_dut (
    .clk(clk), .w_resetn(w_resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .cha_data(cha_data), .cha_addr(cha_addr), .abort(abort),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_unstable(rsp_unstable),
    .rsp_clean(rsp_clean), .clean_err(clean_err)
  );

  rwc_puf_engine #(.DW(8), .N_EVAL(4), .RD_LAT(3)) u_dut_b (
    .clk(clk), .w_resetn(w_resetn),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .cha_data(cha_data_b), .cha_addr(cha_addr_b), .abort(abort_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_din(mem_din_b), .mem_dout(mem_dout_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_write(rsp_write_b), .rsp_unstable(rsp_unstable_b),
    .rsp_clean(rsp_clean_b), .clean_err(clean_err_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard of expected responses
  typedef struct {
    logic [31:0] wr;
    logic [31:0] un;
    logic [31:0] cl;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input logic [31:0] w, input logic [31:0] u,
                              input logic [31:0] c, input logic e, input int l);
    exp_t x;
    x.wr = w; x.un = u; x.cl = c; x.err = e; x.lat = l;
    return x;
  endfunction

  // BRAM model, RD_LAT=1: write number k of a request returns col_tab[k/2]
  // for collision writes (even k) and cln_tab[k/2] for clean writes (odd k).
  logic [31:0] col_tab [16];
  logic [31:0] cln_tab [16];
  int          wr_idx = 0;
  logic [31:0] pipe   = '0;
  assign mem_dout = pipe;

  always @(posedge clk) begin
    if (req_valid && req_ready) wr_idx <= 0;
    else if (mem_en && mem_we) begin
      wr_idx <= wr_idx + 1;
      pipe   <= wr_idx[0] ? cln_tab[wr_idx / 2] : col_tab[wr_idx / 2];
    end
  end

  // BRAM model, RD_LAT=3, clean reads always 0.
  logic [7:0] col8 [16];
  int         wr8 = 0;
  logic [7:0] p8 [3];
  assign mem_dout_b = p8[2];

  always @(posedge clk) begin
    p8[1] <= p8[0];
    p8[2] <= p8[1];
    p8[0] <= 8'h00;
    if (req_valid_b && req_ready_b) wr8 <= 0;
    else if (mem_en_b && mem_we_b) begin
      wr8   <= wr8 + 1;
      p8[0] <= wr8[0] ? 8'h00 : col8[wr8 / 2];
    end
  end

  // Write-pulse monitor
  int         we_tot   = 0;
  int         addr_bad = 0;
  logic [9:0] exp_addr = '0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_tot++;
      if (mem_addr !== exp_addr) addr_bad++;
    end
  end

  task automatic do_req(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    exp_addr  = a;
    cha_addr  = a;
    cha_data  = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 200);
    if (rsp_valid !== 1'b1) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic check_rsp(input string tag, input int lat, input logic [31:0] w,
                           input logic [31:0] u, input logic [31:0] c, input logic e);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    x = sb.pop_front();
    chk({tag, "_lat"},   64'(lat), 64'(x.lat));
    chk({tag, "_write"}, 64'(w),   64'(x.wr));
    chk({tag, "_unst"},  64'(u),   64'(x.un));
    chk({tag, "_clean"}, 64'(c),   64'(x.cl));
    chk({tag, "_err"},   64'(e),   64'(x.err));
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, {62'd0, rsp_valid, req_ready}, 64'b01);
  endtask

  initial begin
    int lat;
    int we0;
    int ab0;
    int seen;

    w_resetn    = 1'b0;
    req_valid   = 1'b0; abort   = 1'b0; rsp_ready   = 1'b0;
    cha_data    = '0;   cha_addr = '0;
    req_valid_b = 1'b0; abort_b = 1'b0; rsp_ready_b = 1'b0;
    cha_data_b  = '0;   cha_addr_b = '0;
    for (int i = 0; i < 16; i++) begin
      col_tab[i] = '0; cln_tab[i] = '0; col8[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {59'd0, req_ready, mem_en, mem_we, rsp_valid, clean_err}, 64'b10000);
    chk("rst_addr_din", {22'd0, mem_addr, mem_din}, 64'd0);
    chk("rst_rsp", {rsp_write, rsp_unstable}, 64'd0);
    chk("rst_clean", 64'(rsp_clean), 64'd0);
    w_resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Stable challenge, defaults
    for (int i = 0; i < 5; i++) col_tab[i] = 32'hA5A5_0F0F;
    we0 = we_tot; ab0 = addr_bad;
    sb.push_back(mk(32'hA5A5_0F0F, 32'h0, 32'h0, 1'b0, 22));
    do_req(10'h155, 32'h1234_5678);
    wait_rsp(lat);
    check_rsp("stable", lat, rsp_write, rsp_unstable, rsp_clean, clean_err);
    chk("stable_we_pulses", 64'(we_tot - we0), 64'd10);
    chk("stable_we_addr", 64'(addr_bad - ab0), 64'd0);
    release_rsp("stable");

    // Noisy bits
    col_tab[0] = 32'h0000_00FF; col_tab[1] = 32'h0000_0F0F; col_tab[2] = 32'h0000_00FF;
    col_tab[3] = 32'h0000_0F0F; col_tab[4] = 32'h0000_00FF;
    sb.push_back(mk(32'h0000_00FF, 32'h0000_0FF0, 32'h0, 1'b0, 22));
    do_req(10'h0A3, 32'hCAFE_F00D);
    wait_rsp(lat);
    check_rsp("noisy", lat, rsp_write, rsp_unstable, rsp_clean, clean_err);
    release_rsp("noisy");

    // Third clean read fails
    for (int i = 0; i < 5; i++) col_tab[i] = 32'hDEAD_BEEF;
    cln_tab[2] = 32'h0000_0001;
    sb.push_back(mk(32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 22));
    do_req(10'h3FF, 32'hDEAD_BEEF);
    wait_rsp(lat);
    check_rsp("cleanerr", lat, rsp_write, rsp_unstable, rsp_clean, clean_err);
    release_rsp("cleanerr");
    cln_tab[2] = 32'h0;

    // Backpressure with a stray request during HOLD; clean_err must clear
    for (int i = 0; i < 5; i++) col_tab[i] = 32'h0F0F_1234;
    sb.push_back(mk(32'h0F0F_1234, 32'h0, 32'h0, 1'b0, 22));
    do_req(10'h001, 32'h0);
    wait_rsp(lat);
    check_rsp("bp", lat, rsp_write, rsp_unstable, rsp_clean, clean_err);
    we0 = we_tot;
    for (int c = 0; c < 20; c++) begin
      req_valid = (c == 5 || c == 6);
      @(negedge clk);
      chk("bp_hold", {29'd0, rsp_valid, req_ready, clean_err, rsp_write},
          {29'd0, 3'b100, 32'h0F0F_1234});
    end
    req_valid = 1'b0;
    chk("bp_no_we", 64'(we_tot - we0), 64'd0);
    release_rsp("bp");

    // Next request after IDLE is accepted normally
    for (int i = 0; i < 5; i++) col_tab[i] = 32'h8000_0001;
    sb.push_back(mk(32'h8000_0001, 32'h0, 32'h0, 1'b0, 22));
    do_req(10'h2AA, 32'h5555_AAAA);
    wait_rsp(lat);
    check_rsp("after_bp", lat, rsp_write, rsp_unstable, rsp_clean, clean_err);
    release_rsp("after_bp");

    // Abort in cycle 7
    for (int i = 0; i < 5; i++) col_tab[i] = 32'hFFFF_FFFF;
    do_req(10'h155, 32'hFFFF_FFFF);
    repeat (7) @(negedge clk);
    chk("abort_c7_we", 64'(mem_we), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_c8_we", {62'd0, mem_en, mem_we}, 64'd0);
    @(negedge clk);
    chk("abort_c9_ready", 64'(req_ready), 64'd1);
    chk("abort_keep_write", 64'(rsp_write), 64'h8000_0001);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);

    // Counters must start clean after the abort
    for (int i = 0; i < 5; i++) col_tab[i] = 32'h0000_0000;
    sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 22));
    do_req(10'h155, 32'h0);
    wait_rsp(lat);
    check_rsp("post_abort", lat, rsp_write, rsp_unstable, rsp_clean, clean_err);
    release_rsp("post_abort");

    // Reset in cycle 7
    for (int i = 0; i < 5; i++) col_tab[i] = 32'h1357_9BDF;
    cln_tab[0] = 32'h0000_0010;
    do_req(10'h0F0, 32'h1357_9BDF);
    repeat (7) @(negedge clk);
    w_resetn = 1'b0;
    @(negedge clk);
    chk("mrst_ctl", {59'd0, req_ready, mem_en, mem_we, rsp_valid, clean_err}, 64'b10000);
    chk("mrst_addr_din", {22'd0, mem_addr, mem_din}, 64'd0);
    chk("mrst_rsp", {rsp_write, rsp_unstable}, 64'd0);
    chk("mrst_clean", 64'(rsp_clean), 64'd0);
    w_resetn   = 1'b1;
    cln_tab[0] = 32'h0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || mem_we === 1'b1) seen++;
    end
    chk("mrst_quiet", 64'(seen), 64'd0);

    // Parameter sweep: DW=8, N_EVAL=4, RD_LAT=3, bit0 set in 2 of 4 evaluations
    col8[0] = 8'h81; col8[1] = 8'h81; col8[2] = 8'h80; col8[3] = 8'h80;
    sb.push_back(mk(32'h80, 32'h01, 32'h0, 1'b0, 34));
    @(negedge clk);
    cha_addr_b  = 10'h077;
    cha_data_b  = 8'h3C;
    req_valid_b = 1'b1;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid_b !== 1'b1 && lat < 200);
    if (rsp_valid_b !== 1'b1) chk("sweep_timeout", 64'(rsp_valid_b), 64'd1);
    check_rsp("sweep", lat, 32'(rsp_write_b), 32'(rsp_unstable_b), 32'(rsp_clean_b), clean_err_b);
    rsp_ready_b = 1'b1;
    @(posedge clk);
    #1 rsp_ready_b = 1'b0;
    @(negedge clk);
    chk("sweep_done", {62'd0, rsp_valid_b, req_ready_b}, 64'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
